async_clk_mult_unit: RTL and testbench
======================================

// Module: async_clk_mult_unit
// PURPOSE
// - Handshake-driven local clock generator plus 32-bit integer multiplier for the async register file.
// - Converts per-channel req/ack pairs (4 channels: read/write ports 1-4) into a gated clock
//   hs_clk and a one-hot channel grant.
// - Produces the registered low-word product Rs*Rm with ARM-style N/Z flags for MUL.
// - Sits beside the register file: req/ack come from the port logic, and hs_clk times register accesses.
// PARAMETERS
// N     32  data width of Rs, Rm, result
// CH    4   number of req/ack handshake channels
// PORTS
// clk      in   1    free-running reference clock; all state updates on posedge
// rst      in   1    asynchronous, active-high reset
// req      in   CH   per-channel request, level (1 = access requested)
// ack      in   CH   per-channel acknowledge, level (1 = access done)
// Rs       in   N    multiplier operand A (unsigned bit pattern)
// Rm       in   N    multiplier operand B
// hs_clk   out  1    gated handshake clock, registered, glitch-free
// grant    out  CH   one-hot lowest-index pending channel, registered; 0 when none pending
// busy     out  1    registered OR of pending channels
// result   out  N    registered low N bits of Rs*Rm
// n_flag   out  1    registered result[N-1]
// z_flag   out  1    registered (result == 0)
// BEHAVIOUR
// - Reset (rst=1, async): hs_clk=0, grant=0, busy=0, result=0, n_flag=0, z_flag=0.
//   Outputs hold these values until the first posedge after rst deasserts.
// - Pending condition per channel: pend[i] = req[i] & ~ack[i] (combinational).
//   - req=1, ack=1 means the access is completed: not pending.
//   - req=0, ack=1 means idle-acked (power-up state ack=0001): not pending.
// - busy <= |pend each posedge.
// - grant <= one-hot of lowest i with pend[i]=1, else 0. Priority is fixed: ch0 > ch1 > ch2 > ch3.
// - hs_clk each posedge:
//   - if |pend, then hs_clk <= ~hs_clk; else hs_clk <= 0.
//   - Result: period = 2 clk cycles while any channel is pending.
//   - First rising edge of hs_clk occurs on the first posedge at which pend is seen.
//   - When pend clears with hs_clk=1, hs_clk falls on the next posedge. There are no runt pulses.
//   - Simultaneous requests on several channels do not change the hs_clk rate; grant arbitrates.
//   - A channel dropping req mid-pulse shifts grant to the next pending channel on the next posedge.
// - Multiplier:
//   - Full N x N unsigned product is computed; only the low N bits are kept.
//   - Low N bits are identical for signed two's-complement operands.
//   - Latency 1 clk: result, n_flag and z_flag update on every posedge from the current Rs/Rm.
//   - Operation is independent of req/ack.
//   - Overflow silently wraps (no carry/V flag).
// - rst asserted mid-operation clears everything immediately. Any partial hs_clk high phase is truncated to 0.
// - No X propagation: all outputs are always driven.
// TESTING
// - rst=1 then release, req=0000 ack=0001 -> hs_clk=0, grant=0000, busy=0 for 10 cycles.
// - req=0001 ack=0000 held 6 cycles -> busy=1, grant=0001 after 1 posedge; hs_clk 1,0,1,0,1,0.
//   Then ack=0001 -> hs_clk=0 within 1 cycle, busy=0.
// - req=0110 ack=0000 -> grant=0010. Then req=0100 -> grant=0100 next posedge, hs_clk keeps toggling.
// - Rs=7, Rm=6 -> result=42, n=0, z=0 after 1 posedge.
//   Rs=0, Rm=0x1234 -> result=0, z=1.
// - Rs=0xFFFFFFFF, Rm=2 -> result=0xFFFFFFFE, n=1.
//   Rs=0x10000, Rm=0x10000 -> result=0, z=1 (wrap).
// - Assert rst while hs_clk=1 and result=42 -> hs_clk=0, result=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/async_clk_mult_unit.sv
// async_clk_mult_unit
// Handshake-driven local clock generator and 32-bit multiplier that sits
// beside the asynchronous register file.
//
// The handshake side turns per-channel req/ack levels into three things:
//   - a gated clock hs_clk that toggles while any channel is pending
//   - a one-hot grant for the lowest-index pending channel
//   - a busy flag
// The multiplier side registers the low word of Rs*Rm together with
// ARM-style N/Z flags.
//
// Ports
//   clk     in   1   free-running reference clock, all state on posedge
//   rst     in   1   asynchronous, active-high reset
//   req     in   CH  per-channel request level
//   ack     in   CH  per-channel acknowledge level
//   Rs      in   N   multiplier operand A
//   Rm      in   N   multiplier operand B
//   hs_clk  out  1   gated handshake clock (registered, glitch-free)
//   grant   out  CH  one-hot lowest pending channel, 0 when none pending
//   busy    out  1   any channel pending
//   result  out  N   low N bits of Rs*Rm
//   n_flag  out  1   result[N-1]
//   z_flag  out  1   result == 0
module async_clk_mult_unit #(
    parameter int N  = 32,
    parameter int CH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] req,
    input  logic [CH-1:0] ack,
    input  logic [N-1:0]  Rs,
    input  logic [N-1:0]  Rm,
    output logic          hs_clk,
    output logic [CH-1:0] grant,
    output logic          busy,
    output logic [N-1:0]  result,
    output logic          n_flag,
    output logic          z_flag
);

    logic [CH-1:0] w_pend;
    logic [CH-1:0] w_grant_nxt;
    logic          w_any_pend;
    logic [N-1:0]  w_prod;

    logic          r_hs_clk;
    logic [CH-1:0] r_grant;
    logic          r_busy;
    logic [N-1:0]  r_result;
    logic          r_n_flag;
    logic          r_z_flag;

    // req=1/ack=1 is a completed access and req=0/ack=1 is idle-acked;
    // only an unacknowledged request counts as pending.
    assign w_pend     = req & ~ack;
    assign w_any_pend = |w_pend;

    // Scan from the top down so the lowest pending index is written last
    // and therefore wins: fixed priority ch0 > ch1 > ...
    always_comb begin
        w_grant_nxt = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_grant_nxt    = '0;
                w_grant_nxt[i] = 1'b1;
            end
        end
    end

    // An N-bit destination keeps exactly the low N bits of the full
    // product; those bits are the same for signed two's-complement operands,
    // and anything above them wraps away with no carry/overflow flag.
    assign w_prod = Rs * Rm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_clk <= 1'b0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_n_flag <= 1'b0;
            r_z_flag <= 1'b0;
        end else begin
            // Toggling from a register gives a 2-cycle period with no runts;
            // forcing 0 when idle ends any high phase on the next edge.
            r_hs_clk <= w_any_pend ? ~r_hs_clk : 1'b0;
            r_grant  <= w_grant_nxt;
            r_busy   <= w_any_pend;
            r_result <= w_prod;
            r_n_flag <= w_prod[N-1];
            r_z_flag <= (w_prod == '0);
        end
    end

    assign hs_clk = r_hs_clk;
    assign grant  = r_grant;
    assign busy   = r_busy;
    assign result = r_result;
    assign n_flag = r_n_flag;
    assign z_flag = r_z_flag;

endmodule

// File: tb/tb_async_clk_mult_unit.sv
// Testbench for async_clk_mult_unit. Reference model tracks the number of
// consecutive pending cycles (hs_clk is high on odd counts), isolates the
// lowest pending bit arithmetically and forms the product in 64 bits.
module tb_async_clk_mult_unit;

    localparam int N  = 32;
    localparam int CH = 4;

    logic          clk;
    logic          rst;
    logic [CH-1:0] req;
    logic [CH-1:0] ack;
    logic [N-1:0]  Rs;
    logic [N-1:0]  Rm;
    logic          hs_clk;
    logic [CH-1:0] grant;
    logic          busy;
    logic [N-1:0]  result;
    logic          n_flag;
    logic          z_flag;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int            m_run;
    logic          m_hs;
    logic [CH-1:0] m_grant;
    logic          m_busy;
    logic [N-1:0]  m_result;
    logic          m_n;
    logic          m_z;

    async_clk_mult_unit #(.N(N), .CH(CH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ack    (ack),
        .Rs     (Rs),
        .Rm     (Rm),
        .hs_clk (hs_clk),
        .grant  (grant),
        .busy   (busy),
        .result (result),
        .n_flag (n_flag),
        .z_flag (z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] obs();
        return {hs_clk, grant, busy, result, n_flag, z_flag};
    endfunction

    function automatic logic [39:0] expv();
        return {m_hs, m_grant, m_busy, m_result, m_n, m_z};
    endfunction

    task automatic model_reset();
        m_run    = 0;
        m_hs     = 1'b0;
        m_grant  = '0;
        m_busy   = 1'b0;
        m_result = '0;
        m_n      = 1'b0;
        m_z      = 1'b0;
    endtask

    // Advance the model by one posedge using the inputs currently applied,
    // then let the DUT take that edge and stop on the following negedge.
    task automatic tick();
        logic [CH-1:0] pend;
        logic [63:0]   p;
        pend = req & ~ack;
        if (pend != 0) begin
            m_run = m_run + 1;
            m_hs  = (m_run % 2) == 1;
        end else begin
            m_run = 0;
            m_hs  = 1'b0;
        end
        m_busy   = (pend != 0);
        m_grant  = pend & (~pend + 4'd1);
        p        = 64'(Rs) * 64'(Rm);
        m_result = p[31:0];
        m_n      = m_result[31];
        m_z      = (m_result == 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        ack = 4'b0001;
        Rs  = '0;
        Rm  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs(), 40'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs() !== expv() || hs_clk !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d got=%h want=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_single_channel();
        logic exp_hs;
        req = 4'b0001;
        ack = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_hs = (i % 2) == 0;
            checks++;
            if (obs() !== expv() || hs_clk !== exp_hs || grant !== 4'b0001 || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_ch cyc=%0d got=%h want=%h hs_want=%0b", i, obs(), expv(), exp_hs);
            end
        end
        ack = 4'b0001;
        tick();
        checks++;
        if (obs() !== expv() || hs_clk !== 1'b0 || busy !== 1'b0 || grant !== 4'b0) begin
            failures++;
            $display("FAIL single_ch_ack got=%h want=%h", obs(), expv());
        end
    endtask

    task automatic test_priority();
        req = 4'b0110;
        ack = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== expv() || grant !== 4'b0010) begin
                failures++;
                $display("FAIL prio_0110 cyc=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        // three pending edges leave hs_clk high; dropping ch1 must not stop it
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== expv() || grant !== 4'b0100 || hs_clk !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL prio_shift cyc=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_mult_directed();
        logic [N-1:0] ta [4];
        logic [N-1:0] tb [4];
        logic [N-1:0] tr [4];
        logic         tn [4];
        logic         tz [4];
        ta = '{32'd7, 32'd0,      32'hFFFF_FFFF, 32'h0001_0000};
        tb = '{32'd6, 32'h1234,   32'd2,         32'h0001_0000};
        tr = '{32'd42, 32'd0,     32'hFFFF_FFFE, 32'd0};
        tn = '{1'b0, 1'b0, 1'b1, 1'b0};
        tz = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            Rs = ta[i];
            Rm = tb[i];
            tick();
            checks++;
            if (obs() !== expv() || result !== tr[i] || n_flag !== tn[i] || z_flag !== tz[i]) begin
                failures++;
                $display("FAIL mult_dir idx=%0d got=%h/%0b/%0b want=%h/%0b/%0b", i,
                         result, n_flag, z_flag, tr[i], tn[i], tz[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req = 4'($urandom_range(0, 15));
            ack = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       begin Rs = $urandom; Rm = $urandom; end
                1:       begin Rs = $urandom_range(0, 255); Rm = $urandom_range(0, 255); end
                2:       begin Rs = '0; Rm = $urandom; end
                default: begin Rs = 32'h1 << $urandom_range(0, 31); Rm = 32'h1 << $urandom_range(0, 31); end
            endcase
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_async_reset();
        req = 4'b0000;
        ack = 4'b0000;
        tick();
        Rs  = 32'd7;
        Rm  = 32'd6;
        req = 4'b0001;
        tick();
        checks++;
        if (obs() !== expv() || hs_clk !== 1'b1 || result !== 32'd42) begin
            failures++;
            $display("FAIL pre_async_rst got=%h want=%h", obs(), expv());
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL async_rst_immediate got=%h want=%h", obs(), 40'h0);
        end
        @(negedge clk);
        checks++;
        if (obs() !== 40'h0) begin
            failures++;
            $display("FAIL async_rst_hold got=%h want=%h", obs(), 40'h0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== expv() || hs_clk !== 1'b1 || result !== 32'd42) begin
            failures++;
            $display("FAIL post_async_rst got=%h want=%h", obs(), expv());
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_priority();
        test_mult_directed();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
